// File: rtl/ifetch_queue.sv
// Fetch stage behind the PC register: imem request/grant/response handshake
// plus a small in-order queue of {pc, pc+4, instr} entries feeding decode.
module ifetch_queue #(
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] pcf,
    input  logic [31:0] pcplus4,
    output logic        pc_adv,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        flush,
    output logic        valid_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [PW-1:0] FULL = PW'(DEPTH);

    logic [PW-1:0] alloc_ptr, fill_ptr, rd_ptr, drop_cnt;
    logic [PW-1:0] count, pending, drop_sum, drop_next;
    logic [AW-1:0] alloc_idx, fill_idx, rd_idx;
    logic          fill_ok, drop_hit, pop;

    logic [31:0] pc_q    [DEPTH];
    logic [31:0] pc4_q   [DEPTH];
    logic [31:0] instr_q [DEPTH];

    assign alloc_idx = alloc_ptr[AW-1:0];
    assign fill_idx  = fill_ptr[AW-1:0];
    assign rd_idx    = rd_ptr[AW-1:0];

    // count includes slots already granted but still waiting for data
    assign count   = alloc_ptr - rd_ptr;
    assign pending = alloc_ptr - fill_ptr;

    assign imem_req  = en & rst & ~flush & (count < FULL);
    assign pc_adv    = imem_req & imem_gnt;
    assign imem_addr = pcf;

    assign valid_d  = (fill_ptr != rd_ptr);
    assign fill_ok  = en & ~flush & imem_rvalid & (drop_cnt == '0) & (pending != '0);
    assign drop_hit = en & ~flush & imem_rvalid & (drop_cnt != '0);
    assign pop      = en & ~flush & valid_d & ~stall_d;

    assign instr_d   = valid_d ? instr_q[rd_idx] : NOP;
    assign pc_d      = valid_d ? pc_q[rd_idx]    : 32'h0;
    assign pcplus4_d = valid_d ? pc4_q[rd_idx]   : 32'h0;

    // A response landing in the flush cycle belongs to the discarded set.
    always_comb begin
        drop_sum  = drop_cnt + pending;
        drop_next = drop_sum;
        if (imem_rvalid && (drop_sum != '0))
            drop_next = drop_sum - ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= '0;
        end else if (en) begin
            if (flush) begin
                alloc_ptr <= '0;
                fill_ptr  <= '0;
                rd_ptr    <= '0;
                drop_cnt  <= drop_next;
            end else begin
                if (pc_adv)
                    alloc_ptr <= alloc_ptr + ONE;
                if (fill_ok)
                    fill_ptr <= fill_ptr + ONE;
                if (drop_hit)
                    drop_cnt <= drop_cnt - ONE;
                if (pop)
                    rd_ptr <= rd_ptr + ONE;
            end
        end
    end

    // Payload needs no reset: it is only visible behind valid_d.
    always_ff @(posedge clk) begin
        if (pc_adv) begin
            pc_q[alloc_idx]  <= pcf;
            pc4_q[alloc_idx] <= pcplus4;
        end
        if (fill_ok)
            instr_q[fill_idx] <= imem_rdata;
    end

endmodule
